// File: rtl/wb2stream.sv
// ============================================================================
// Module  : wb2stream
// Brief   : Wishbone slave that serialises bus accesses into bridge command
//           bytes and collects the 4-byte read response from the remote end.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb2stream #(
    parameter logic [6:0] BUS_ID    = 7'd0,
    parameter int         TIMEOUT_W = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] wb_addr,
    input  logic [31:0] wb_wdata,
    output logic [31:0] wb_rdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TX_HDR = 3'd1,
        S_TX_DAT = 3'd2,
        S_RX_DAT = 3'd3,
        S_ACK    = 3'd4
    } state_t;

    localparam logic [TIMEOUT_W-1:0] c_CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [1:0]            r_idx;
    logic [15:0]           r_addr;
    logic [31:0]           r_wdata;
    logic                  r_we;
    logic [23:0]           r_shift;
    logic [TIMEOUT_W-1:0]  r_cnt;

    logic                  w_xfer;
    logic [TIMEOUT_W-1:0]  w_cnt_inc;
    logic                  w_timeout;
    logic [7:0]            w_hdr_next;
    logic [7:0]            w_dat_next;

    assign w_xfer    = tx_valid & tx_ready;
    assign w_cnt_inc = r_cnt + c_CNT_ONE;
    // Fires in the idle cycle that would bring the counter to all-ones.
    assign w_timeout = &w_cnt_inc;

    // Byte that follows the one currently on tx_data.
    always_comb begin
        w_hdr_next = 8'h00;
        case (r_idx)
            2'd0:    w_hdr_next = r_addr[15:8];
            2'd1:    w_hdr_next = r_addr[7:0];
            default: w_hdr_next = r_wdata[31:24];
        endcase
    end

    always_comb begin
        w_dat_next = 8'h00;
        case (r_idx)
            2'd0:    w_dat_next = r_wdata[23:16];
            2'd1:    w_dat_next = r_wdata[15:8];
            2'd2:    w_dat_next = r_wdata[7:0];
            default: w_dat_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= 2'd0;
            r_addr      <= 16'h0000;
            r_wdata     <= 32'h0000_0000;
            r_we        <= 1'b0;
            r_shift     <= 24'h00_0000;
            r_cnt       <= '0;
            wb_ack      <= 1'b0;
            wb_rdata    <= 32'h0000_0000;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            wb_ack      <= 1'b0;
            err_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wb_cyc && !wb_ack) begin
                        r_addr   <= wb_addr;
                        r_wdata  <= wb_wdata;
                        r_we     <= wb_we;
                        r_idx    <= 2'd0;
                        tx_data  <= {wb_we, BUS_ID};
                        tx_valid <= 1'b1;
                        r_state  <= S_TX_HDR;
                    end
                end
                S_TX_HDR: begin
                    if (w_xfer) begin
                        if (r_idx == 2'd2) begin
                            r_idx <= 2'd0;
                            if (r_we) begin
                                tx_data <= w_hdr_next;
                                r_state <= S_TX_DAT;
                            end else begin
                                tx_valid <= 1'b0;
                                r_cnt    <= '0;
                                r_shift  <= 24'h00_0000;
                                r_state  <= S_RX_DAT;
                            end
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            tx_data <= w_hdr_next;
                        end
                    end
                end
                S_TX_DAT: begin
                    if (w_xfer) begin
                        if (r_idx == 2'd3) begin
                            tx_valid <= 1'b0;
                            wb_ack   <= 1'b1;
                            r_state  <= S_ACK;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            tx_data <= w_dat_next;
                        end
                    end
                end
                S_RX_DAT: begin
                    // A byte arriving together with the timeout is dropped.
                    if (w_timeout) begin
                        wb_rdata    <= 32'hFFFF_FFFF;
                        wb_ack      <= 1'b1;
                        err_timeout <= 1'b1;
                        r_state     <= S_ACK;
                    end else if (rx_valid) begin
                        r_cnt <= '0;
                        if (r_idx == 2'd3) begin
                            wb_rdata <= {r_shift, rx_data};
                            wb_ack   <= 1'b1;
                            r_state  <= S_ACK;
                        end else begin
                            r_shift <= {r_shift[15:0], rx_data};
                            r_idx   <= r_idx + 2'd1;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb2stream.sv
// ============================================================================
// Module  : tb_wb2stream
// Brief   : Directed self-checking bench for wb2stream (BUS_ID 2 and 0 copies).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb2stream;

    logic        clk;
    logic        rst_n;
    logic [15:0] wb_addr;
    logic [31:0] wb_wdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic [31:0] rdata2, rdata0;
    logic        ack2, ack0;
    logic [7:0]  txd2, txd0;
    logic        txv2, txv0;
    logic        err2, err0;

    wb2stream #(.BUS_ID(7'd2), .TIMEOUT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
        .wb_rdata(rdata2), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(ack2),
        .tx_data(txd2), .tx_valid(txv2), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .err_timeout(err2)
    );

    wb2stream #(.BUS_ID(7'd0), .TIMEOUT_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
        .wb_rdata(rdata0), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(ack0),
        .tx_data(txd0), .tx_valid(txv0), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .err_timeout(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total;
    int         bad;
    logic [7:0] q2[$];
    logic [7:0] q0[$];
    int         viol;
    logic       stall_pend;
    logic [7:0] stall_d;
    int         acks2;
    int         acks0;
    int         errs0;

    task automatic tick();
        @(negedge clk);
    endtask

    // Log transfers/acks using the inputs that will be sampled at the next edge.
    task automatic sample();
        if (txv2 && tx_ready) q2.push_back(txd2);
        if (txv0 && tx_ready) q0.push_back(txd0);
        if (stall_pend && (txv2 !== 1'b1 || txd2 !== stall_d)) viol++;
        stall_pend = txv2 && !tx_ready;
        stall_d    = txd2;
        if (ack2) acks2++;
        if (ack0) acks0++;
        if (err0) errs0++;
    endtask

    task automatic clear_log();
        q2.delete();
        q0.delete();
        viol       = 0;
        stall_pend = 1'b0;
        acks2      = 0;
        acks0      = 0;
        errs0      = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (ack2 !== 1'b0 || ack0 !== 1'b0) begin bad++; $display("FAIL reset_ack got %b/%b want 0", ack2, ack0); end
        total++; if (rdata2 !== 32'h0 || rdata0 !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h/%h want 0", rdata2, rdata0); end
        total++; if (txv2 !== 1'b0 || txv0 !== 1'b0) begin bad++; $display("FAIL reset_txvalid got %b/%b want 0", txv2, txv0); end
        total++; if (txd2 !== 8'h00 || txd0 !== 8'h00) begin bad++; $display("FAIL reset_txdata got %h/%h want 00", txd2, txd0); end
        total++; if (err2 !== 1'b0 || err0 !== 1'b0) begin bad++; $display("FAIL reset_err got %b/%b want 0", err2, err0); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        logic [7:0] exp [7];
        int ack_at;
        exp = '{8'h82, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        clear_log();
        ack_at   = -1;
        tx_ready = 1'b1;
        wb_addr  = 16'h1234;
        wb_wdata = 32'hDEAD_BEEF;
        wb_we    = 1'b1;
        wb_cyc   = 1'b1;
        sample();
        for (int n = 1; n <= 20; n++) begin
            tick();
            sample();
            if (ack2 && ack_at < 0) begin
                ack_at = n;
                wb_cyc = 1'b0;
            end
        end
        total++; if (q2.size() != 7) begin bad++; $display("FAIL write_count got %0d want 7", q2.size()); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (i >= q2.size() || q2[i] !== exp[i]) begin
                bad++; $display("FAIL write_byte%0d got %h want %h", i, (i < q2.size()) ? q2[i] : 8'hxx, exp[i]);
            end
        end
        total++; if (q0.size() == 0 || q0[0] !== 8'h80) begin bad++; $display("FAIL write_cmd_bus0 got %h want 80", (q0.size() > 0) ? q0[0] : 8'hxx); end
        total++; if (ack_at != 8) begin bad++; $display("FAIL write_latency got %0d want 8", ack_at); end
        total++; if (acks2 != 1) begin bad++; $display("FAIL write_acks got %0d want 1", acks2); end
        total++; if (errs0 != 0) begin bad++; $display("FAIL write_err got %0d want 0", errs0); end
    endtask

    task automatic test_read();
        logic [7:0] b [4];
        int early;
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_log();
        early    = 0;
        tx_ready = 1'b1;
        wb_addr  = 16'h00F0;
        wb_wdata = 32'h0;
        wb_we    = 1'b0;
        wb_cyc   = 1'b1;
        sample();
        for (int n = 1; n <= 4; n++) begin
            tick();
            sample();
        end
        total++; if (q0.size() != 3) begin bad++; $display("FAIL read_count got %0d want 3", q0.size()); end
        total++; if (q0.size() < 3 || q0[0] !== 8'h00 || q0[1] !== 8'h00 || q0[2] !== 8'hF0) begin bad++; $display("FAIL read_hdr got %p want 00 00 F0", q0); end
        total++; if (q2.size() == 0 || q2[0] !== 8'h02) begin bad++; $display("FAIL read_cmd_bus2 got %p want 02", q2); end
        rx_data  = b[0];
        rx_valid = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            if (ack0) early++;
            rx_data = b[i];
        end
        tick();
        rx_valid = 1'b0;
        total++; if (early != 0) begin bad++; $display("FAIL read_early_ack got %0d want 0", early); end
        total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL read_ack got %b want 1", ack0); end
        total++; if (rdata0 !== 32'h1122_3344) begin bad++; $display("FAIL read_rdata got %h want 11223344", rdata0); end
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL read_err got %b want 0", err0); end
        wb_cyc = 1'b0;
        tick();
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL read_ack_width got %b want 0", ack0); end
        total++; if (rdata0 !== 32'h1122_3344) begin bad++; $display("FAIL read_rdata_hold got %h want 11223344", rdata0); end
    endtask

    task automatic test_stall();
        logic [7:0]  exp [7];
        logic [31:0] pat;
        int ack_at;
        exp = '{8'h82, 8'h0B, 8'hAD, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        pat = 32'b1011_0010_0111_0001_1100_1010_0110_1101;
        clear_log();
        ack_at   = -1;
        wb_addr  = 16'h0BAD;
        wb_wdata = 32'hCAFE_F00D;
        wb_we    = 1'b1;
        wb_cyc   = 1'b1;
        tx_ready = pat[0];
        sample();
        for (int n = 1; n <= 60; n++) begin
            tick();
            tx_ready = pat[n % 32];
            sample();
            if (ack2 && ack_at < 0) begin
                ack_at = n;
                wb_cyc = 1'b0;
            end
        end
        tx_ready = 1'b1;
        total++; if (q2.size() != 7) begin bad++; $display("FAIL stall_count got %0d want 7", q2.size()); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (i >= q2.size() || q2[i] !== exp[i]) begin
                bad++; $display("FAIL stall_byte%0d got %h want %h", i, (i < q2.size()) ? q2[i] : 8'hxx, exp[i]);
            end
        end
        total++; if (viol != 0) begin bad++; $display("FAIL stall_stable got %0d changes want 0", viol); end
        total++; if (acks2 != 1 || ack_at < 0) begin bad++; $display("FAIL stall_acks got %0d want 1", acks2); end
    endtask

    task automatic test_timeout();
        int early;
        clear_log();
        early    = 0;
        tx_ready = 1'b1;
        wb_addr  = 16'h0044;
        wb_we    = 1'b0;
        wb_cyc   = 1'b1;
        for (int n = 1; n <= 4; n++) tick();
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        tick();
        rx_data  = 8'hBB;
        tick();
        rx_valid = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (ack0) early++;
        end
        tick();
        total++; if (early != 0) begin bad++; $display("FAIL timeout_early got %0d want 0", early); end
        total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL timeout_ack got %b want 1", ack0); end
        total++; if (rdata0 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL timeout_rdata got %h want ffffffff", rdata0); end
        total++; if (err0 !== 1'b1) begin bad++; $display("FAIL timeout_err got %b want 1", err0); end
        wb_cyc = 1'b0;
        tick();
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL timeout_err_width got %b want 0", err0); end
        rx_data  = 8'hCC;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        total++; if (ack0 !== 1'b0 || txv0 !== 1'b0) begin bad++; $display("FAIL late_byte got ack=%b txv=%b want 0 0", ack0, txv0); end
        total++; if (rdata0 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL late_byte_rdata got %h want ffffffff", rdata0); end
    endtask

    task automatic test_stray();
        logic [7:0] b [4];
        int early;
        b = '{8'h01, 8'h02, 8'h03, 8'h04};
        clear_log();
        early    = 0;
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        total++; if (ack0 !== 1'b0 || txv0 !== 1'b0) begin bad++; $display("FAIL stray_idle got ack=%b txv=%b want 0 0", ack0, txv0); end
        tx_ready = 1'b1;
        wb_addr  = 16'h0100;
        wb_we    = 1'b0;
        wb_cyc   = 1'b1;
        sample();
        for (int n = 1; n <= 4; n++) begin
            tick();
            sample();
        end
        total++; if (q0.size() != 3 || q0[0] !== 8'h00 || q0[1] !== 8'h01 || q0[2] !== 8'h00) begin bad++; $display("FAIL stray_hdr got %p want 00 01 00", q0); end
        for (int i = 0; i < 4; i++) begin
            rx_data  = b[i];
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            if (i < 3) begin
                if (ack0) early++;
                tick();
                if (ack0) early++;
            end
        end
        total++; if (early != 0) begin bad++; $display("FAIL stray_early got %0d want 0", early); end
        total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL stray_ack got %b want 1", ack0); end
        total++; if (rdata0 !== 32'h0102_0304) begin bad++; $display("FAIL stray_rdata got %h want 01020304", rdata0); end
        wb_cyc = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [7];
        int ack_at;
        exp = '{8'h82, 8'h0F, 8'h0F, 8'h00, 8'hFF, 8'h7E, 8'h81};
        clear_log();
        tx_ready = 1'b1;
        wb_addr  = 16'h5A5A;
        wb_wdata = 32'h1357_9BDF;
        wb_we    = 1'b1;
        wb_cyc   = 1'b1;
        sample();
        for (int n = 1; n <= 7; n++) begin
            tick();
            sample();
        end
        total++; if (txv2 !== 1'b1 || txd2 !== 8'hDF) begin bad++; $display("FAIL midrst_lastbyte got v=%b d=%h want 1 df", txv2, txd2); end
        rst_n  = 1'b0;
        wb_cyc = 1'b0;
        tick();
        sample();
        total++; if (txv2 !== 1'b0 || ack2 !== 1'b0) begin bad++; $display("FAIL midrst_abort got v=%b ack=%b want 0 0", txv2, ack2); end
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            sample();
        end
        total++; if (acks2 != 0 || q2.size() != 7) begin bad++; $display("FAIL midrst_quiet got acks=%0d bytes=%0d want 0 7", acks2, q2.size()); end
        clear_log();
        ack_at   = -1;
        wb_addr  = 16'h0F0F;
        wb_wdata = 32'h00FF_7E81;
        wb_cyc   = 1'b1;
        sample();
        for (int n = 1; n <= 20; n++) begin
            tick();
            sample();
            if (ack2 && ack_at < 0) begin
                ack_at = n;
                wb_cyc = 1'b0;
            end
        end
        total++; if (q2.size() != 7) begin bad++; $display("FAIL fresh_count got %0d want 7", q2.size()); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (i >= q2.size() || q2[i] !== exp[i]) begin
                bad++; $display("FAIL fresh_byte%0d got %h want %h", i, (i < q2.size()) ? q2[i] : 8'hxx, exp[i]);
            end
        end
        total++; if (acks2 != 1 || ack_at != 8) begin bad++; $display("FAIL fresh_ack got n=%0d at=%0d want 1 8", acks2, ack_at); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        wb_addr  = 16'h0;
        wb_wdata = 32'h0;
        wb_we    = 1'b0;
        wb_cyc   = 1'b0;
        tx_ready = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        clear_log();
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_timeout();
        test_stray();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
